gray_scan_ctrl: RTL and testbench

GRAY_SCAN_CTRL -- requirements
Module: gray_scan_ctrl

---
 rtl/gray_scan_pkg.sv | 14 +
 rtl/gray2bin_dec.sv | 16 +
 rtl/gray_scan_ctrl.sv | 146 ++++++++++++++
 tb/tb_gray_scan_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_scan_pkg.sv
// Shared types and helpers for the Gray-code channel scanner.
package gray_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    OUT    = 2'd2
  } state_t;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gray2bin_dec.sv
// Combinational Gray-to-binary decoder.
module gray2bin_dec #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  always_comb begin
    bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/gray_scan_ctrl.sv
// Periodic scanner: samples enabled Gray channels in
// ascending order and hands each decoded value to a consumer.
module gray_scan_ctrl
  import gray_scan_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int CHANNELS    = 4,
  parameter int SCAN_PERIOD = 2700000
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [CHANNELS*WIDTH-1:0]    gray_bus_i,
  input  logic [CHANNELS-1:0]          ch_en_i,
  input  logic                         ready_i,
  input  logic                         ovr_clr_i,
  output logic [WIDTH-1:0]             bin_o,
  output logic [ch_width(CHANNELS)-1:0] ch_o,
  output logic                         valid_o,
  output logic                         busy_o,
  output logic                         overrun_o
);

  localparam int CW = ch_width(CHANNELS);
  localparam int PW = $clog2(SCAN_PERIOD);
  localparam int BW = CHANNELS * WIDTH;
  localparam logic [PW-1:0] RELOAD = PW'(SCAN_PERIOD - 1);

  logic [BW-1:0]       sync1, sync2;
  logic [PW-1:0]       cnt;
  logic                tick;
  state_t              state, state_nx;
  logic [CHANNELS-1:0] mask, mask_nx;
  logic [CW-1:0]       sel, sel_nx;
  logic [CW-1:0]       first, nxt;
  logic                has_first, has_nxt;
  logic [WIDTH-1:0]    gray_sel, dec;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= gray_bus_i;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt <= RELOAD;
    end else if (cnt == '0) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = (cnt == '0);

  // Lowest enabled channel, and next enabled channel above sel.
  always_comb begin
    first     = '0;
    has_first = 1'b0;
    nxt       = '0;
    has_nxt   = 1'b0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (ch_en_i[i]) begin
        first     = CW'(i);
        has_first = 1'b1;
      end
      if (mask[i] && (i > int'(sel))) begin
        nxt     = CW'(i);
        has_nxt = 1'b1;
      end
    end
  end

  assign gray_sel = sync2[int'(sel)*WIDTH +: WIDTH];

  gray2bin_dec #(
    .WIDTH(WIDTH)
  ) u_dec (
    .gray(gray_sel),
    .bin (dec)
  );

  always_comb begin
    state_nx = state;
    mask_nx  = mask;
    sel_nx   = sel;
    case (state)
      IDLE: begin
        if (tick && has_first) begin
          state_nx = SAMPLE;
          mask_nx  = ch_en_i;
          sel_nx   = first;
        end
      end
      SAMPLE: state_nx = OUT;
      OUT: begin
        if (ready_i) begin
          if (has_nxt) begin
            state_nx = SAMPLE;
            sel_nx   = nxt;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      mask  <= '0;
      sel   <= '0;
      bin_o <= '0;
      ch_o  <= '0;
    end else begin
      state <= state_nx;
      mask  <= mask_nx;
      sel   <= sel_nx;
      if (state == SAMPLE) begin
        bin_o <= dec;
        ch_o  <= sel;
      end
    end
  end

  // A tick seen mid-scan is dropped but flagged; set beats clear.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      overrun_o <= 1'b0;
    end else if (tick && (state != IDLE)) begin
      overrun_o <= 1'b1;
    end else if (ovr_clr_i) begin
      overrun_o <= 1'b0;
    end
  end

  assign valid_o = (state == OUT);
  assign busy_o  = (state != IDLE);

endmodule

// File: tb/tb_gray_scan_ctrl.sv
// Randomized bench for gray_scan_ctrl against a queue-based
// transaction model of the scan sequence.
module tb_gray_scan_ctrl;

  localparam int W = 4;
  localparam int C = 4;
  localparam int P = 8;

  logic           clk = 1'b0;
  logic           rst_i;
  logic [C*W-1:0] gray_bus;
  logic [C-1:0]   ch_en;
  logic           ready;
  logic           ovr_clr;
  logic [W-1:0]   bin;
  logic [1:0]     ch;
  logic           valid;
  logic           busy;
  logic           overrun;

  always #5 clk = ~clk;

  gray_scan_ctrl #(
    .WIDTH(W),
    .CHANNELS(C),
    .SCAN_PERIOD(P)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .gray_bus_i(gray_bus),
    .ch_en_i   (ch_en),
    .ready_i   (ready),
    .ovr_clr_i (ovr_clr),
    .bin_o     (bin),
    .ch_o      (ch),
    .valid_o   (valid),
    .busy_o    (busy),
    .overrun_o (overrun)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Transaction model: pending outputs of the current scan.
  int q_ch[$];
  int q_bin[$];
  int k;
  int due;
  int m_ovr;
  int first_valid;
  int log_ch[$];
  int log_bin[$];
  bit rand_gray = 0;
  bit g_pend = 0;
  logic [C*W-1:0] g_val;

  function automatic int g2b(input int g);
    int b;
    int s;
    b = 0;
    s = g;
    while (s != 0) begin
      b = b ^ s;
      s = s >> 1;
    end
    return b;
  endfunction

  task automatic model_reset();
    q_ch.delete();
    q_bin.delete();
    k = 0;
    due = 0;
    m_ovr = 0;
    first_valid = 0;
  endtask

  task automatic advance();
    bit tick;
    bit bsy;
    bit vexp;
    tick = (k % P) == (P - 1);
    bsy  = q_ch.size() > 0;
    vexp = bsy && (k >= due);
    if (vexp && ready) begin
      void'(q_ch.pop_front());
      void'(q_bin.pop_front());
      due = k + 2;
    end
    if (tick && bsy) m_ovr = 1;
    else if (ovr_clr) m_ovr = 0;
    if (tick && !bsy && (ch_en != '0)) begin
      for (int i = 0; i < C; i++) begin
        if (ch_en[i]) begin
          q_ch.push_back(i);
          q_bin.push_back(g2b(int'(gray_bus[i*W +: W])));
        end
      end
      due = k + 2;
    end
    k++;
  endtask

  task automatic check_out();
    bit bsy;
    bit vexp;
    bsy  = q_ch.size() > 0;
    vexp = bsy && (k >= due);
    chk("valid", valid, vexp);
    chk("busy", busy, bsy);
    chk("overrun", overrun, m_ovr);
    if (vexp) begin
      chk("ch", ch, q_ch[0]);
      chk("bin", bin, q_bin[0]);
    end
    if (valid && first_valid == 0) first_valid = k + 1;
  endtask

  task automatic step(input logic [C-1:0] en, input logic rdy,
                      input logic clr);
    @(negedge clk);
    check_out();
    ch_en   = en;
    ready   = rdy;
    ovr_clr = clr;
    if (rand_gray && !g_pend && $urandom_range(0, 3) == 0) begin
      for (int i = 0; i < C; i++) g_val[i*W +: W] = W'($urandom);
      g_pend = 1;
    end
    // Inputs change only well clear of a tick and of any pending sample.
    if (g_pend && q_ch.size() == 0 && (k % P) <= P - 5) begin
      gray_bus = g_val;
      g_pend = 0;
    end
    if (valid && rdy) begin
      log_ch.push_back(int'(ch));
      log_bin.push_back(int'(bin));
    end
    advance();
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 50 && q_ch.size() > 0; n++) step('0, 1'b1, 1'b0);
    if (q_ch.size() > 0) chk("idle_timeout", 1, 0);
  endtask

  int exp_bin[4] = '{0, 2, 15, 12};
  int held;
  int cnt_bad;
  bit hit;

  initial begin
    rst_i = 1'b0;
    ch_en = '0;
    ready = 1'b0;
    ovr_clr = 1'b0;
    gray_bus = 16'b1010_1000_0011_0000;
    repeat (3) @(negedge clk);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_bin", bin, 0);
    chk("rst_ch", ch, 0);
    rst_i = 1'b1;
    model_reset();
    ch_en = 4'hF;
    ready = 1'b1;
    advance();

    // Full scan of four channels.
    log_ch.delete();
    log_bin.delete();
    repeat (2 * P + 4) step(4'hF, 1'b1, 1'b0);
    chk("s1_count", log_ch.size(), 4);
    for (int i = 0; i < 4 && i < log_ch.size(); i++) begin
      chk("s1_ch", log_ch[i], i);
      chk("s1_bin", log_bin[i], exp_bin[i]);
    end
    chk("s1_first_valid", first_valid, P + 2);
    wait_idle();
    step('0, 1'b1, 1'b1);

    // Sparse mask with a stalled consumer.
    wait_idle();
    log_ch.delete();
    held = 0;
    for (int n = 0; n < 60 && held < 10; n++) begin
      step(4'b0101, 1'b0, 1'b0);
      if (valid) held++;
    end
    chk("s2_hold", held, 10);
    chk("s2_ovr", overrun, 1);
    repeat (3 * P) step(4'b0101, 1'b1, 1'b0);
    wait_idle();
    chk("s2_first_ch", log_ch.size() > 0 ? log_ch[0] : -1, 0);
    chk("s2_second_ch", log_ch.size() > 1 ? log_ch[1] : -1, 2);
    cnt_bad = 0;
    foreach (log_ch[i]) if (log_ch[i] == 1 || log_ch[i] == 3) cnt_bad++;
    chk("s2_skipped", cnt_bad, 0);

    step('0, 1'b1, 1'b1);
    step('0, 1'b1, 1'b0);
    chk("s3_clr", overrun, 0);

    // Clear coinciding with a tick while busy.
    hit = 0;
    for (int n = 0; n < 40 && !hit; n++) begin
      if ((k % P) == P - 1 && q_ch.size() > 0) begin
        hit = 1;
        step(4'hF, 1'b0, 1'b1);
      end else begin
        step(4'hF, 1'b0, 1'b0);
      end
    end
    chk("s3_hit", hit, 1);
    step(4'hF, 1'b0, 1'b0);
    chk("s3_set_wins", overrun, 1);
    wait_idle();

    // No enabled channels: nothing happens.
    cnt_bad = 0;
    for (int n = 0; n < 2 * P; n++) begin
      step('0, 1'b1, 1'b0);
      if (busy || valid) cnt_bad++;
    end
    chk("s4_idle", cnt_bad, 0);

    // Enable change mid-scan has no effect.
    log_ch.delete();
    for (int n = 0; n < 20 && q_ch.size() == 0; n++) step(4'hF, 1'b1, 1'b0);
    repeat (12) step(4'b0001, 1'b1, 1'b0);
    chk("s4_count", log_ch.size(), 4);
    for (int i = 0; i < 4 && i < log_ch.size(); i++) chk("s4_ch", log_ch[i], i);
    wait_idle();

    rand_gray = 1;
    repeat (800) begin
      step(C'($urandom), 1'($urandom_range(0, 9) < 7),
           1'($urandom_range(0, 19) == 0));
    end
    rand_gray = 0;
    wait_idle();

    // Asynchronous reset while a value is presented.
    held = 0;
    for (int n = 0; n < 40 && !valid; n++) step(4'hF, 1'b0, 1'b0);
    chk("r_in_out", valid, 1);
    #2 rst_i = 1'b0;
    #1;
    chk("r_valid", valid, 0);
    chk("r_busy", busy, 0);
    chk("r_ovr", overrun, 0);
    chk("r_bin", bin, 0);
    chk("r_ch", ch, 0);
    @(negedge clk);
    rst_i = 1'b1;
    model_reset();
    ch_en = 4'hF;
    ready = 1'b1;
    ovr_clr = 1'b0;
    advance();
    repeat (P + 4) step(4'hF, 1'b1, 1'b0);
    chk("r_first_valid", first_valid, P + 2);
    wait_idle();

    // Every Gray code on channel 0.
    for (int code = 0; code < (1 << W); code++) begin
      g_val = gray_bus;
      g_val[W-1:0] = W'(code);
      g_pend = 1;
      log_bin.delete();
      log_ch.delete();
      for (int n = 0; n < 6 * P && log_bin.size() == 0; n++) begin
        step(g_pend ? 4'b0000 : 4'b0001, 1'b1, 1'b0);
      end
      chk("sweep_bin", log_bin.size() > 0 ? log_bin[0] : -1, g2b(code));
      chk("sweep_ch", log_ch.size() > 0 ? log_ch[0] : -1, 0);
    end
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
